// File: rtl/avalon_main_mem_responder.sv
// Avalon-MM main-memory responder: 65-bit words (bit 64 = tag), byte-lane writes, SLVERR on out-of-range reads.
// Latency: WaitStates stall cycles before accept; read data returned exactly ReadLatency cycles after accept.
// Backpressure: waitrequest held while wait states count down or MaxPending reads are outstanding; responses never stall.
module avalon_main_mem_responder #(
  parameter int AddrWidth   = 10,
  parameter int WaitStates  = 0,
  parameter int ReadLatency = 2,
  parameter int MaxPending  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] avs_address,
  input  logic [7:0]  avs_byteenable,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [64:0] avs_writedata,
  output logic        avs_waitrequest,
  output logic [64:0] avs_readdata,
  output logic        avs_readdatavalid,
  output logic [1:0]  avs_response
);

  localparam int         Depth    = 1 << AddrWidth;
  localparam bit         NoWait   = (WaitStates == 0);
  localparam logic [3:0] WaitInit = NoWait ? 4'd0 : 4'(WaitStates - 1);
  localparam logic [3:0] MaxPend  = 4'(MaxPending);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [3:0]           pending_q;
  logic                 cmd;
  logic                 slot_free;
  logic                 in_range;
  logic                 wait_req;
  logic                 accept;
  logic                 rd_acc;
  logic                 wr_acc;
  logic [AddrWidth-1:0] word_addr;

  logic [64:0] mem [Depth];

  // Read pipeline: one slot per cycle of latency; the last slot drives the response.
  logic        stage_vld [ReadLatency];
  logic [64:0] stage_dat [ReadLatency];
  logic        stage_err [ReadLatency];
  logic        rsp_vld;

  assign cmd       = avs_read | avs_write;
  assign slot_free = (pending_q < MaxPend);
  assign in_range  = ((avs_address >> AddrWidth) == 32'd0);
  assign word_addr = avs_address[AddrWidth-1:0];
  assign accept    = cmd & ~wait_req;
  // A combined read+write performs only the write; the read half is dropped.
  assign rd_acc    = accept & avs_read & ~avs_write;
  assign wr_acc    = accept & avs_write & in_range;
  assign rsp_vld   = stage_vld[ReadLatency-1];

  // State and wait counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and waitrequest; pending compare uses the registered count only.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_req = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (cmd) begin
          if (NoWait && slot_free) begin
            wait_req = 1'b0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WaitInit;
          end
        end
      end
      ST_WAIT: begin
        if (!cmd) begin
          // Master withdrew the command: abandon it without side effects.
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (slot_free) begin
          wait_req = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (rst_i) begin
      wait_req = 1'b1;
    end
  end

  assign avs_waitrequest = wait_req;

  // RAM write: enabled byte lanes update; tag survives only a full-word write.
  always_ff @(posedge clk_i) begin
    if (wr_acc) begin
      for (int b = 0; b < 8; b++) begin
        if (avs_byteenable[b]) begin
          mem[word_addr][8*b +: 8] <= avs_writedata[8*b +: 8];
        end
      end
      mem[word_addr][64] <= (avs_byteenable == 8'hFF) ? avs_writedata[64] : 1'b0;
    end
  end

  // Read pipeline: capture at accept, shift every cycle, flush on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < ReadLatency; i++) begin
        stage_vld[i] <= 1'b0;
        stage_dat[i] <= '0;
        stage_err[i] <= 1'b0;
      end
    end else begin
      stage_vld[0] <= rd_acc;
      stage_dat[0] <= (rd_acc && in_range) ? mem[word_addr] : '0;
      stage_err[0] <= rd_acc & ~in_range;
      for (int i = 1; i < ReadLatency; i++) begin
        stage_vld[i] <= stage_vld[i-1];
        stage_dat[i] <= stage_dat[i-1];
        stage_err[i] <= stage_err[i-1];
      end
    end
  end

  // Outstanding-read counter: up on read accept, down on response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= 4'd0;
    end else begin
      case ({rd_acc, rsp_vld})
        2'b10:   pending_q <= pending_q + 4'd1;
        2'b01:   pending_q <= pending_q - 4'd1;
        default: pending_q <= pending_q;
      endcase
    end
  end

  assign avs_readdatavalid = rsp_vld;
  assign avs_readdata      = rsp_vld ? stage_dat[ReadLatency-1] : '0;
  assign avs_response      = (rsp_vld && stage_err[ReadLatency-1]) ? 2'b10 : 2'b00;

endmodule

// File: tb/tb_avalon_main_mem_responder.sv
// Bench for avalon_main_mem_responder: three instances with different wait/latency/pending settings.
// Directed steps followed by random traffic, all checked against a transaction-level memory/response model.
// Responses are matched in order against due cycles; waitrequest is checked every cycle a command is presented.
module tb_avalon_main_mem_responder;

  logic        clk = 1'b0;
  logic        rst   [3];
  logic [31:0] addr  [3];
  logic [7:0]  be    [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [64:0] wdat  [3];
  logic        wreq  [3];
  logic [64:0] rdat  [3];
  logic        rdv   [3];
  logic [1:0]  resp  [3];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct {
    int          k;
    int          due;
    logic [64:0] d;
    logic [64:0] m;
    logic [1:0]  r;
  } exp_t;

  exp_t        expq [$];
  int          acc_k [$];
  int          acc_due [$];
  logic [64:0] mmem   [3][1024];
  logic [64:0] mknown [3][1024];
  int          mon_idx;

  avalon_main_mem_responder #(.AddrWidth(10), .WaitStates(0), .ReadLatency(2), .MaxPending(4)) u0 (
    .clk_i(clk), .rst_i(rst[0]), .avs_address(addr[0]), .avs_byteenable(be[0]),
    .avs_read(rd[0]), .avs_write(wr[0]), .avs_writedata(wdat[0]), .avs_waitrequest(wreq[0]),
    .avs_readdata(rdat[0]), .avs_readdatavalid(rdv[0]), .avs_response(resp[0]));

  avalon_main_mem_responder #(.AddrWidth(10), .WaitStates(3), .ReadLatency(3), .MaxPending(4)) u1 (
    .clk_i(clk), .rst_i(rst[1]), .avs_address(addr[1]), .avs_byteenable(be[1]),
    .avs_read(rd[1]), .avs_write(wr[1]), .avs_writedata(wdat[1]), .avs_waitrequest(wreq[1]),
    .avs_readdata(rdat[1]), .avs_readdatavalid(rdv[1]), .avs_response(resp[1]));

  avalon_main_mem_responder #(.AddrWidth(10), .WaitStates(0), .ReadLatency(4), .MaxPending(2)) u2 (
    .clk_i(clk), .rst_i(rst[2]), .avs_address(addr[2]), .avs_byteenable(be[2]),
    .avs_read(rd[2]), .avs_write(wr[2]), .avs_writedata(wdat[2]), .avs_waitrequest(wreq[2]),
    .avs_readdata(rdat[2]), .avs_readdatavalid(rdv[2]), .avs_response(resp[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ws_of(input int k);
    return (k == 1) ? 3 : 0;
  endfunction
  function automatic int rl_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 3 : 4);
  endfunction
  function automatic int mp_of(input int k);
    return (k == 2) ? 2 : 4;
  endfunction

  task automatic chk(input int k, input string tag, input logic [64:0] obs, input logic [64:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL u%0d %s: observed %h, expected %h", k, tag, obs, expv);
    end
  endtask

  function automatic int outstanding(input int k);
    int n = 0;
    foreach (expq[i]) if (expq[i].k == k) n++;
    return n;
  endfunction

  // Response monitor: each cycle either the oldest expected read for that port is due, or the bus is quiet.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst[k] === 1'b0) begin
        mon_idx = -1;
        for (int i = 0; i < expq.size(); i++) begin
          if (expq[i].k == k) begin
            mon_idx = i;
            break;
          end
        end
        if (mon_idx >= 0 && expq[mon_idx].due == cyc) begin
          chk(k, "rdv", 65'(rdv[k]), 65'd1);
          chk(k, "rdata", rdat[k] & expq[mon_idx].m, expq[mon_idx].d & expq[mon_idx].m);
          chk(k, "resp", 65'(resp[k]), 65'(expq[mon_idx].r));
          expq.delete(mon_idx);
        end else begin
          chk(k, "rdv_quiet", 65'(rdv[k]), 65'd0);
          chk(k, "rdata_quiet", rdat[k], 65'd0);
          chk(k, "resp_quiet", 65'(resp[k]), 65'd0);
        end
        if (!rd[k] && !wr[k]) chk(k, "wreq_idle", 65'(wreq[k]), 65'd1);
      end
    end
  end

  task automatic clear_model_q(input int k);
    for (int i = expq.size() - 1; i >= 0; i--) if (expq[i].k == k) expq.delete(i);
    for (int i = acc_k.size() - 1; i >= 0; i--) begin
      if (acc_k[i] == k) begin
        acc_k.delete(i);
        acc_due.delete(i);
      end
    end
  endtask

  task automatic model_accept(input int k, input logic r, input logic w, input logic [31:0] a,
                              input logic [7:0] bsel, input logic [64:0] d, input int acc);
    exp_t       e;
    logic [9:0] wa;
    wa = a[9:0];
    if (w) begin
      if (a < 32'd1024) begin
        for (int i = 0; i < 8; i++) begin
          if (bsel[i]) begin
            mmem[k][wa][8*i +: 8]   = d[8*i +: 8];
            mknown[k][wa][8*i +: 8] = 8'hFF;
          end
        end
        mmem[k][wa][64]   = (bsel == 8'hFF) ? d[64] : 1'b0;
        mknown[k][wa][64] = 1'b1;
      end
    end else if (r) begin
      acc_k.push_back(k);
      acc_due.push_back(acc + rl_of(k));
      e.k   = k;
      e.due = acc + rl_of(k);
      if (a < 32'd1024) begin
        e.d = mmem[k][wa];
        e.m = mknown[k][wa];
        e.r = 2'b00;
      end else begin
        e.d = '0;
        e.m = '1;
        e.r = 2'b10;
      end
      expq.push_back(e);
    end
  endtask

  // Present one command from the start of a cycle; check waitrequest each cycle until accepted.
  task automatic issue(input int k, input logic r, input logic w, input logic [31:0] a,
                       input logic [7:0] bsel, input logic [64:0] d, output int acc);
    int s;
    int p;
    s   = cyc;
    acc = -1;
    rd[k] = r; wr[k] = w; addr[k] = a; be[k] = bsel; wdat[k] = d;
    for (int t = 0; t < 64 && acc < 0; t++) begin
      @(negedge clk);
      p = 0;
      foreach (acc_due[i]) if (acc_k[i] == k && acc_due[i] >= cyc) p++;
      chk(k, "wreq", 65'(wreq[k]), 65'(!((cyc >= s + ws_of(k)) && (p < mp_of(k)))));
      if (wreq[k] === 1'b0) acc = cyc;
      @(posedge clk); #1;
    end
    rd[k] = 1'b0;
    wr[k] = 1'b0;
    if (acc < 0) chk(k, "accept_timeout", 65'd0, 65'd1);
    else model_accept(k, r, w, a, bsel, d, acc);
  endtask

  task automatic expect_at(input int k, input int target, input logic [64:0] d, input logic [1:0] r);
    if (cyc > target) chk(k, "expect_late", 65'(cyc), 65'(target));
    while (cyc < target) begin @(posedge clk); #1; end
    @(negedge clk);
    chk(k, "dir_rdv", 65'(rdv[k]), 65'd1);
    chk(k, "dir_rdata", rdat[k], d);
    chk(k, "dir_resp", 65'(resp[k]), 65'(r));
    @(posedge clk); #1;
  endtask

  task automatic drain(input int k);
    for (int t = 0; t < 40 && outstanding(k) != 0; t++) begin @(posedge clk); #1; end
    if (outstanding(k) != 0) begin
      chk(k, "drain_timeout", 65'(outstanding(k)), 65'd0);
      clear_model_q(k);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s, a0, a1, a2, a3, nrdv, op, gap;
    logic [31:0] ra;
    logic [7:0]  rb;
    logic [64:0] rdw;

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; rd[k] = 1'b0; wr[k] = 1'b0; addr[k] = '0; be[k] = '0; wdat[k] = '0;
      for (int i = 0; i < 1024; i++) begin
        mmem[k][i]   = '0;
        mknown[k][i] = '0;
      end
    end

    // Reset held three cycles: quiet outputs and waitrequest high.
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk(k, "rst_wreq", 65'(wreq[k]), 65'd1);
      chk(k, "rst_rdv", 65'(rdv[k]), 65'd0);
      chk(k, "rst_rdata", rdat[k], 65'd0);
      chk(k, "rst_resp", 65'(resp[k]), 65'd0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    @(negedge clk);
    chk(0, "idle_wreq", 65'(wreq[0]), 65'd1);
    @(posedge clk); #1;

    // Zero-wait read accepted in the presenting cycle, OKAY two cycles later.
    s = cyc;
    issue(0, 1'b1, 1'b0, 32'h5, 8'hFF, '0, a0);
    chk(0, "acc_same_cycle", 65'(a0), 65'(s));
    drain(0);

    // Full write then immediate read-back.
    issue(0, 1'b0, 1'b1, 32'h10, 8'hFF, {1'b1, 64'hDEADBEEF_01234567}, a0);
    issue(0, 1'b1, 1'b0, 32'h10, 8'hFF, '0, a1);
    chk(0, "raw_b2b", 65'(a1 - a0), 65'd1);
    expect_at(0, a1 + 2, 65'h1_DEADBEEF_01234567, 2'b00);

    // Partial write with tag=1 still clears the tag.
    issue(0, 1'b0, 1'b1, 32'h10, 8'h0F, {1'b1, 64'h00000000_AABBCCDD}, a0);
    issue(0, 1'b1, 1'b0, 32'h10, 8'hFF, '0, a1);
    expect_at(0, a1 + 2, 65'h0_DEADBEEF_AABBCCDD, 2'b00);

    // Out of range: read gives SLVERR, write is discarded (does not alias onto word 0).
    issue(0, 1'b0, 1'b1, 32'h0, 8'hFF, {1'b0, 64'h11223344_55667788}, a0);
    issue(0, 1'b1, 1'b0, 32'h400, 8'hFF, '0, a1);
    expect_at(0, a1 + 2, 65'h0, 2'b10);
    issue(0, 1'b0, 1'b1, 32'h400, 8'hFF, {1'b1, 64'hFFFFFFFF_FFFFFFFF}, a0);
    issue(0, 1'b1, 1'b0, 32'h0, 8'hFF, '0, a1);
    expect_at(0, a1 + 2, 65'h0_11223344_55667788, 2'b00);

    // Combined read+write: write lands, no response.
    issue(0, 1'b1, 1'b1, 32'h20, 8'hFF, {1'b1, 64'h0BADF00D_CAFEBABE}, a0);
    issue(0, 1'b1, 1'b0, 32'h20, 8'hFF, '0, a1);
    expect_at(0, a1 + 2, 65'h1_0BADF00D_CAFEBABE, 2'b00);
    drain(0);

    // Three wait states: accept on the fourth cycle, data three cycles later.
    issue(1, 1'b0, 1'b1, 32'h1, 8'hFF, {1'b1, 64'h01020304_05060708}, a0);
    s = cyc;
    issue(1, 1'b1, 1'b0, 32'h1, 8'hFF, '0, a1);
    chk(1, "wait_states", 65'(a1 - s), 65'd3);
    expect_at(1, a1 + 3, 65'h1_01020304_05060708, 2'b00);

    // Pending limit of two: third read waits until the slot freed by the first response is registered.
    issue(2, 1'b1, 1'b0, 32'h2, 8'hFF, '0, a0);
    issue(2, 1'b1, 1'b0, 32'h3, 8'hFF, '0, a1);
    issue(2, 1'b1, 1'b0, 32'h400, 8'hFF, '0, a2);
    issue(2, 1'b1, 1'b0, 32'h5, 8'hFF, '0, a3);
    chk(2, "second_b2b", 65'(a1 - a0), 65'd1);
    chk(2, "third_after_slot", 65'(a2 - a0), 65'd5);
    chk(2, "fourth_b2b", 65'(a3 - a2), 65'd1);
    drain(2);

    // Reset with two reads in flight: nothing comes back afterwards.
    issue(2, 1'b1, 1'b0, 32'h2, 8'hFF, '0, a0);
    issue(2, 1'b1, 1'b0, 32'h3, 8'hFF, '0, a1);
    rst[2] = 1'b1;
    clear_model_q(2);
    @(posedge clk); #1;
    rst[2] = 1'b0;
    nrdv = 0;
    repeat (10) begin
      @(negedge clk);
      if (rdv[2] === 1'b1) nrdv++;
      @(posedge clk); #1;
    end
    chk(2, "rdv_after_reset", 65'(nrdv), 65'd0);
    issue(2, 1'b1, 1'b0, 32'h400, 8'hFF, '0, a0);
    expect_at(2, a0 + 4, 65'h0, 2'b10);

    // Random traffic on every instance, checked by the model.
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 60; n++) begin
        op = $urandom_range(0, 19);
        case ($urandom_range(0, 7))
          0:       ra = 32'h400 + 32'($urandom_range(0, 255));
          1:       ra = $urandom | 32'h8000_0000;
          default: ra = 32'($urandom_range(0, 15));
        endcase
        case ($urandom_range(0, 3))
          0:       rb = 8'h00;
          1, 2:    rb = 8'hFF;
          default: rb = 8'($urandom);
        endcase
        rdw = {1'($urandom_range(0, 1)), $urandom, $urandom};
        if (op == 0) begin
          issue(k, 1'b1, 1'b1, ra, rb, rdw, a0);
        end else if (op < 9) begin
          issue(k, 1'b0, 1'b1, ra, rb, rdw, a0);
        end else if (op < 19) begin
          issue(k, 1'b1, 1'b0, ra, rb, rdw, a0);
        end else begin
          gap = $urandom_range(1, 3);
          repeat (gap) begin @(posedge clk); #1; end
        end
      end
      drain(k);
    end

    repeat (4) begin @(posedge clk); #1; end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/avalon_main_mem_responder.md
Name: avalon_main_mem_responder

Overview:
- Avalon-MM slave (responder) that terminates the 65-bit main data interface driven by the core wrapper's Avalon master: 64 data bits plus 1 tag bit in bit 64, 8-bit byteenable, word-addressed.
- Provides on-chip RAM with configurable wait states and pipelined read latency.
- Returns SLVERR for out-of-range reads.
- Serves as the simulation/FPGA main-memory endpoint and as the protocol reference responder for the translator.

Parameters:
- AddrWidth, 10, word-address bits; depth = 2**AddrWidth 65-bit words.
- WaitStates, 0, cycles waitrequest is held high before each command is accepted (0..15).
- ReadLatency, 2, cycles from read acceptance to readdatavalid (1..8).
- MaxPending, 4, maximum reads in flight (1..8).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active high
- avs_address  in  32  word address
- avs_byteenable  in  8  byte lanes for data bits 63:0
- avs_read  in  1  read command
- avs_write  in  1  write command
- avs_writedata  in  65  write data; bit 64 is the tag
- avs_waitrequest  out  1  command not accepted this cycle
- avs_readdata  out  65  read data
- avs_readdatavalid  out  1  read response valid
- avs_response  out  2  00 OKAY, 10 SLVERR; valid with readdatavalid

Behaviour:
- Clocking: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: waitrequest=1 while rst_i is high; readdatavalid=0, readdata=0, response=00, pending=0, FSM=IDLE.
- Reset mid-operation: all in-flight reads are discarded; no readdatavalid after reset releases. RAM contents are not cleared.
- Command: cmd = avs_read | avs_write.
- Accept: a command is accepted in a cycle where cmd=1 and waitrequest=0. waitrequest is combinational from state, counter, pending and cmd.
- FSM IDLE:
  - If cmd and WaitStates=0 and pending<MaxPending: waitrequest=0 (accept).
  - Elif cmd: waitrequest=1 and go to WAIT with cnt=WaitStates-1 (cnt=0 when WaitStates=0, i.e. stalled only by pending).
  - No cmd: waitrequest=1.
- FSM WAIT:
  - waitrequest=1 while cnt!=0, decrementing each cycle.
  - When cnt=0 and pending<MaxPending: waitrequest=0, accept, go to IDLE.
  - If the master drops cmd in WAIT (protocol violation): return to IDLE with no side effects.
- Master stability: master holds address, data and byteenable stable while waitrequest=1. The block samples only at acceptance.
- Range check: in range iff avs_address[31:AddrWidth]==0.
- Write (accepted, in range):
  - For each byte b with byteenable[b]=1, mem[addr][8b+7:8b] is updated at the next edge.
  - Tag: mem[addr][64] <= (byteenable==8'hFF) ? writedata[64] : 0. A partial write always clears the tag.
  - byteenable=0 leaves data unchanged and clears the tag.
- Write out of range: silently discarded; no response (writes carry no response).
- Read (accepted):
  - The data word is captured and returned on readdata with readdatavalid=1 for exactly 1 cycle.
  - That cycle is exactly ReadLatency cycles after the accept cycle.
  - Responses are in order; the pipeline is never stalled.
- Read out of range: readdata=0, response=10. In range: response=00.
- Outside readdatavalid: readdata and response return to 0.
- Read after write: a read accepted the cycle after a write to the same address returns the new data (write-first visible on the next edge).
- Simultaneous read and write in one command: illegal. The write is performed, the read is dropped (no readdatavalid), and it counts as one acceptance.
- Pending counter:
  - +1 on read accept, -1 on readdatavalid; both in one cycle leaves it unchanged.
  - Never exceeds MaxPending. At pending==MaxPending, waitrequest=1 even if cnt=0.
  - A slot freed by a readdatavalid in the same cycle does not enable acceptance until the next cycle (registered compare).
- Back-to-back: with WaitStates=0, one command per cycle is sustained while pending<MaxPending.

Test Plan:
- Reset, defaults: rst_i held 3 cycles → waitrequest=1, readdatavalid=0, readdata=0. After release with idle bus → waitrequest=1. Read addr 0x5 accepted same cycle → readdatavalid at +2 with response=00.
- Full write then read: write addr 0x10, data {1, 64'hDEADBEEF_01234567}, be=FF. Read 0x10 next cycle → readdata=65'h1_DEADBEEF_01234567 at accept+2.
- Partial write clears tag: after the above, write 0x10 be=8'h0F data 64'h0...AABBCCDD with tag=1. Read → 65'h0_DEADBEEF_AABBCCDD.
- Out of range: AddrWidth=10, read addr 0x400 → readdatavalid with readdata=0, response=10. Write 0x400 then read 0x000 → 0x000 unchanged.
- Wait states: WaitStates=3, read 0x1 → waitrequest high 3 cycles, low on the 4th. readdatavalid ReadLatency cycles after that.
- Backpressure and reset: MaxPending=2, ReadLatency=4, reads every cycle:
  - 2 accepted, then waitrequest=1 until the first readdatavalid frees a slot.
  - Responses arrive in order.
  - Assert rst_i with 2 pending → no readdatavalid after release.
